// File: rtl/mux_sel_arbiter.sv
// Two-channel round-robin arbiter driving the select of a 2:1 data mux.
// Grants are bounded bursts of BURST_LEN cycles under contention; sel only
// moves when a new grant is issued, so the mux output never toggles while idle.
module mux_sel_arbiter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CW        = $clog2(BURST_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  output logic          sel,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          busy,
  output logic [CW-1:0] burst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  // Encoding of the "last granted" bit; B after reset so A wins the first tie.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;

  // Next-state, burst counter, select and round-robin pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_a && req_b) begin
          state_d = (last_q == LAST_B) ? GNT_A : GNT_B;
        end else if (req_a) begin
          state_d = GNT_A;
        end else if (req_b) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (!req_a) begin
          state_d = req_b ? GNT_B : IDLE;
        end else if (cnt_q == LAST_CNT) begin
          if (req_b) state_d = GNT_B;
          else       cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_d = req_a ? GNT_A : IDLE;
        end else if (cnt_q == LAST_CNT) begin
          if (req_a) state_d = GNT_A;
          else       cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Any state change starts a fresh burst (or parks the counter in IDLE).
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == GNT_A) begin
        sel_d  = 1'b0;
        last_d = LAST_A;
      end else if (state_d == GNT_B) begin
        sel_d  = 1'b1;
        last_d = LAST_B;
      end
    end
  end

  // Grant outputs decoded ahead of the register so they leave a flop directly.
  always_comb begin
    gnt_a_d = (state_d == GNT_A);
    gnt_b_d = (state_d == GNT_B);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= LAST_B;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  assign sel       = sel_q;
  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign busy      = gnt_a_q | gnt_b_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed request patterns, a cycle model of the
// arbitration rules checked on every falling edge, and literal spot checks.
module tb_mux_sel_arbiter;

  localparam int unsigned BL = 4;
  localparam int unsigned CW = $clog2(BL);

  logic          clk;
  logic          rst_n;
  logic          req_a;
  logic          req_b;
  logic          sel;
  logic          gnt_a;
  logic          gnt_b;
  logic          busy;
  logic [CW-1:0] burst_cnt;

  mux_sel_arbiter #(.BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .sel       (sel),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: owner 0 = nobody, 1 = A, 2 = B; cyc = cycles into current burst.
  int m_owner = 0;
  int m_cyc   = 0;
  int m_sel   = 0;
  int m_last  = 2;

  function automatic void m_give(input int who);
    m_owner = who;
    m_cyc   = 0;
    m_sel   = (who == 2) ? 1 : 0;
    m_last  = who;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_cyc = 0; m_sel = 0; m_last = 2;
    end else begin
      int r[3];
      r[0] = 0; r[1] = int'(req_a); r[2] = int'(req_b);
      if (m_owner == 0) begin
        if (r[1] == 1 && r[2] == 1) m_give(3 - m_last);
        else if (r[1] == 1)         m_give(1);
        else if (r[2] == 1)         m_give(2);
      end else begin
        int other;
        other = 3 - m_owner;
        if (r[m_owner] == 0) begin
          if (r[other] == 1) m_give(other);
          else begin m_owner = 0; m_cyc = 0; end
        end else if (m_cyc == BL - 1) begin
          if (r[other] == 1) m_give(other);
          else m_cyc = 0;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gnt_a", int'(gnt_a), (m_owner == 1) ? 1 : 0);
      check("m_gnt_b", int'(gnt_b), (m_owner == 2) ? 1 : 0);
      check("m_busy",  int'(busy),  (m_owner != 0) ? 1 : 0);
      check("m_sel",   int'(sel),   m_sel);
      check("m_cnt",   int'(burst_cnt), m_cyc);
    end
  end

  task automatic drive(input logic a, input logic b);
    req_a = a;
    req_b = b;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1);
    chk_en = 1'b1;
    cycles(3);
    check("rst_sel", int'(sel), 0);
    check("rst_gnt", int'({gnt_a, gnt_b}), 0);
    check("rst_cnt", int'(burst_cnt), 0);
    check("rst_busy", int'(busy), 0);

    // Contention from reset release: A first, 4/4 alternation.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("tie_gnt_a", int'(gnt_a), 1);
        check("tie_sel",   int'(sel), 0);
      end
      if (k == 4) check("a_cnt3", int'(burst_cnt), 3);
      if (k == 5) begin
        check("swap_gnt_b", int'(gnt_b), 1);
        check("swap_sel",   int'(sel), 1);
        check("swap_cnt",   int'(burst_cnt), 0);
      end
      if (k == 9) check("back_to_a", int'({gnt_a, sel}), 2);
    end

    // Lone requester A: burst counter restarts, sel stays 0.
    drive(1'b1, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 4) check("lone_cnt3", int'(burst_cnt), 3);
      if (j == 5) begin
        check("lone_restart", int'(burst_cnt), 0);
        check("lone_gnt_a",   int'(gnt_a), 1);
      end
    end
    check("lone_cnt1", int'(burst_cnt), 1);

    // Early release at cnt=1 with B waiting.
    drive(1'b0, 1'b1);
    cycles(1);
    check("early_gnt_b", int'(gnt_b), 1);
    check("early_sel",   int'(sel), 1);
    check("early_cnt",   int'(burst_cnt), 0);

    // Back to A at cnt=1, then drop both: idle with sel held.
    drive(1'b1, 1'b0);
    cycles(2);
    check("a_again_cnt1", int'(burst_cnt), 1);
    drive(1'b0, 1'b0);
    cycles(1);
    check("idle_busy", int'(busy), 0);
    check("idle_sel",  int'(sel), 0);
    cycles(2);

    // Both high after idle: B wins since A was served last.
    drive(1'b1, 1'b1);
    cycles(1);
    check("rr_gnt_b", int'(gnt_b), 1);
    check("rr_sel",   int'(sel), 1);
    cycles(2);
    check("b_cnt2", int'(burst_cnt), 2);

    // Async reset pulse between edges during GNT_B at cnt=2.
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", int'({gnt_a, gnt_b}), 0);
    check("arst_sel", int'(sel), 0);
    check("arst_cnt", int'(burst_cnt), 0);
    check("arst_busy", int'(busy), 0);
    #1 rst_n = 1'b1;
    cycles(1);
    check("post_rst_gnt_a", int'(gnt_a), 1);
    check("post_rst_sel",   int'(sel), 0);

    cycles(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: run did not complete, got %0d expected finish", n_checks);
    $fatal(1);
  end

endmodule
